// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// decode_issue : instruction decode / register read / issue with 2-entry skid
//                buffer and same-cycle write-back bypass
// Revision     : 1.0
// ============================================================================
module decode_issue #(
  parameter int DBITS               = 32,
  parameter int INST_BIT_WIDTH      = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int OP_BIT_WIDTH        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  // Fetch side
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INST_BIT_WIDTH-1:0]      in_inst,
  input  logic [DBITS-1:0]               in_pc,
  // Register file read
  output logic [REG_INDEX_BIT_WIDTH-1:0] rf_idx1,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rf_idx2,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rf_idxd,
  input  logic [DBITS-1:0]               rf_data1,
  input  logic [DBITS-1:0]               rf_data2,
  input  logic [DBITS-1:0]               rf_datad,
  // Write-back bypass
  input  logic                           wb_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_idx,
  input  logic [DBITS-1:0]               wb_data,
  // Execute side
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DBITS-1:0]               out_regd,
  output logic [DBITS-1:0]               out_reg1,
  output logic [DBITS-1:0]               out_reg2,
  output logic [DBITS-1:0]               out_imm32,
  output logic [DBITS-1:0]               out_pc,
  output logic [15:0]                    out_immHi,
  output logic                           out_useZero,
  output logic                           out_useImm,
  output logic                           out_isMvhi,
  output logic                           out_isBranchOrCond,
  output logic [OP_BIT_WIDTH-1:0]        out_opAlu,
  output logic [OP_BIT_WIDTH-1:0]        out_opCond,
  output logic [REG_INDEX_BIT_WIDTH-1:0] out_rd,
  output logic                           out_wrReg,
  output logic                           out_isLoad,
  output logic                           out_isStore,
  output logic                           out_isBranch,
  output logic                           out_isJal,
  output logic                           out_illegal
);

  localparam logic [3:0] OP1_ALUR  = 4'b0000;
  localparam logic [3:0] OP1_ALUI  = 4'b1000;
  localparam logic [3:0] OP1_CMPR  = 4'b0010;
  localparam logic [3:0] OP1_CMPI  = 4'b1010;
  localparam logic [3:0] OP1_BCOND = 4'b0110;
  localparam logic [3:0] OP1_SW    = 4'b0101;
  localparam logic [3:0] OP1_LW    = 4'b1001;
  localparam logic [3:0] OP1_JAL   = 4'b1011;

  typedef struct packed {
    logic [DBITS-1:0]               regd;
    logic [DBITS-1:0]               reg1;
    logic [DBITS-1:0]               reg2;
    logic [DBITS-1:0]               imm32;
    logic [DBITS-1:0]               pc;
    logic [15:0]                    imm_hi;
    logic                           use_zero;
    logic                           use_imm;
    logic                           is_mvhi;
    logic                           is_branch_or_cond;
    logic [OP_BIT_WIDTH-1:0]        op_alu;
    logic [OP_BIT_WIDTH-1:0]        op_cond;
    logic [REG_INDEX_BIT_WIDTH-1:0] rd;
    logic                           wr_reg;
    logic                           is_load;
    logic                           is_store;
    logic                           is_branch;
    logic                           is_jal;
    logic                           illegal;
  } issue_t;

  // Instruction fields
  logic [3:0]                     op1;
  logic [3:0]                     op2;
  logic [REG_INDEX_BIT_WIDTH-1:0] rd;
  logic [REG_INDEX_BIT_WIDTH-1:0] rs1;
  logic [REG_INDEX_BIT_WIDTH-1:0] rs2;
  logic [15:0]                    imm16;

  assign op1   = in_inst[31:28];
  assign op2   = in_inst[27:24];
  assign rd    = in_inst[23:20];
  assign rs1   = in_inst[19:16];
  assign rs2   = in_inst[15:12];
  assign imm16 = in_inst[15:0];

  assign rf_idx1 = rs1;
  assign rf_idx2 = rs2;
  assign rf_idxd = rd;

  function automatic logic [DBITS-1:0] bypass(
    input logic                           en,
    input logic [REG_INDEX_BIT_WIDTH-1:0] widx,
    input logic [DBITS-1:0]               wdata,
    input logic [REG_INDEX_BIT_WIDTH-1:0] ridx,
    input logic [DBITS-1:0]               rdata
  );
    return (en && (widx == ridx)) ? wdata : rdata;
  endfunction

  // Decode
  issue_t dec;
  logic   is_branch_raw;
  logic   is_sw_raw;
  logic   legal;
  logic   wr_reg_raw;

  always_comb begin
    is_branch_raw = op1[2] & ~op1[0];
    is_sw_raw     = op1[2] & op1[0];
    legal         = 1'b0;
    wr_reg_raw    = 1'b0;

    case (op1)
      OP1_ALUR: begin
        wr_reg_raw = 1'b1;
        legal = (op2 == 4'h0) || (op2 == 4'h1) || (op2 == 4'h4) || (op2 == 4'h5) ||
                (op2 == 4'h6) || (op2 == 4'hC) || (op2 == 4'hD) || (op2 == 4'hE);
      end
      OP1_ALUI: begin
        wr_reg_raw = 1'b1;
        legal = (op2 == 4'h0) || (op2 == 4'h1) || (op2 == 4'h4) || (op2 == 4'h5) ||
                (op2 == 4'h6) || (op2 == 4'hC) || (op2 == 4'hD) || (op2 == 4'hE) ||
                (op2 == 4'hB);
      end
      OP1_CMPR, OP1_CMPI: begin
        wr_reg_raw = 1'b1;
        legal      = (op2 != 4'h4) && (op2 != 4'hC);
      end
      OP1_BCOND: legal = (op2 != 4'h4) && (op2 != 4'hC);
      OP1_SW:    legal = (op2 == 4'h0);
      OP1_LW, OP1_JAL: begin
        wr_reg_raw = 1'b1;
        legal      = (op2 == 4'h0);
      end
      default: legal = 1'b0;
    endcase

    dec                   = '0;
    dec.regd              = bypass(wb_en, wb_idx, wb_data, rd,  rf_datad);
    dec.reg1              = bypass(wb_en, wb_idx, wb_data, rs1, rf_data1);
    dec.reg2              = bypass(wb_en, wb_idx, wb_data, rs2, rf_data2);
    dec.imm32             = {{(DBITS-16){imm16[15]}}, imm16};
    dec.pc                = in_pc;
    dec.imm_hi            = imm16;
    dec.is_mvhi           = op1[3] & ~op1[1] & op2[1] & op2[0];
    dec.use_zero          = (is_branch_raw & op2[2]) | dec.is_mvhi;
    dec.use_imm           = op1[3] | is_sw_raw;
    dec.is_branch_or_cond = op1[1] & ~op1[0];
    dec.op_alu            = dec.is_branch_or_cond ? 4'b0001 : op2;
    dec.op_cond           = op2;
    dec.rd                = rd;
    // Illegal encodings still issue, but with every side effect suppressed
    dec.illegal           = ~legal;
    dec.wr_reg            = legal & wr_reg_raw;
    dec.is_load           = legal & (op1 == OP1_LW);
    dec.is_store          = legal & (op1 == OP1_SW);
    dec.is_branch         = legal & (op1 == OP1_BCOND);
    dec.is_jal            = legal & (op1 == OP1_JAL);
  end

  // Two-entry buffer: main drives the outputs, skid absorbs one beat of backpressure
  issue_t main_q, main_d;
  issue_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   pop;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // accept implies skid empty, so a popping main is free for the new entry
      if (accept) begin
        if (!main_valid_q || pop) begin
          main_d       = dec;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid          = main_valid_q;
  assign out_regd           = main_q.regd;
  assign out_reg1           = main_q.reg1;
  assign out_reg2           = main_q.reg2;
  assign out_imm32          = main_q.imm32;
  assign out_pc             = main_q.pc;
  assign out_immHi          = main_q.imm_hi;
  assign out_useZero        = main_q.use_zero;
  assign out_useImm         = main_q.use_imm;
  assign out_isMvhi         = main_q.is_mvhi;
  assign out_isBranchOrCond = main_q.is_branch_or_cond;
  assign out_opAlu          = main_q.op_alu;
  assign out_opCond         = main_q.op_cond;
  assign out_rd             = main_q.rd;
  assign out_wrReg          = main_q.wr_reg;
  assign out_isLoad         = main_q.is_load;
  assign out_isStore        = main_q.is_store;
  assign out_isBranch       = main_q.is_branch;
  assign out_isJal          = main_q.is_jal;
  assign out_illegal        = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// tb_decode_issue : directed self-checking bench for decode_issue
// Revision        : 1.0
// ============================================================================
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [3:0]  rf_idx1, rf_idx2, rf_idxd;
  logic [31:0] rf_data1, rf_data2, rf_datad;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_regd, out_reg1, out_reg2, out_imm32, out_pc;
  logic [15:0] out_immHi;
  logic        out_useZero, out_useImm, out_isMvhi, out_isBranchOrCond;
  logic [3:0]  out_opAlu, out_opCond, out_rd;
  logic        out_wrReg, out_isLoad, out_isStore, out_isBranch, out_isJal, out_illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_issue u_dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_inst           (in_inst),
    .in_pc             (in_pc),
    .rf_idx1           (rf_idx1),
    .rf_idx2           (rf_idx2),
    .rf_idxd           (rf_idxd),
    .rf_data1          (rf_data1),
    .rf_data2          (rf_data2),
    .rf_datad          (rf_datad),
    .wb_en             (wb_en),
    .wb_idx            (wb_idx),
    .wb_data           (wb_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_regd          (out_regd),
    .out_reg1          (out_reg1),
    .out_reg2          (out_reg2),
    .out_imm32         (out_imm32),
    .out_pc            (out_pc),
    .out_immHi         (out_immHi),
    .out_useZero       (out_useZero),
    .out_useImm        (out_useImm),
    .out_isMvhi        (out_isMvhi),
    .out_isBranchOrCond(out_isBranchOrCond),
    .out_opAlu         (out_opAlu),
    .out_opCond        (out_opCond),
    .out_rd            (out_rd),
    .out_wrReg         (out_wrReg),
    .out_isLoad        (out_isLoad),
    .out_isStore       (out_isStore),
    .out_isBranch      (out_isBranch),
    .out_isJal         (out_isJal),
    .out_illegal       (out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    rf_data1  = '0;
    rf_data2  = '0;
    rf_datad  = '0;
    wb_en     = 1'b0;
    wb_idx    = '0;
    wb_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_reg1",      out_reg1,  0);
    check("rst_wrReg",     out_wrReg, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // ADD r3 <- r1 + r2
    rf_data1 = 32'd8;
    rf_data2 = 32'd3;
    rf_datad = 32'h55;
    in_inst  = 32'h0031_2000;
    #1;
    check("add_idx1", rf_idx1, 1);
    check("add_idx2", rf_idx2, 2);
    check("add_idxd", rf_idxd, 3);
    send(32'h0031_2000, 32'h100);
    in_valid = 1'b0;
    check("add_valid",  out_valid,  1);
    check("add_reg1",   out_reg1,   8);
    check("add_reg2",   out_reg2,   3);
    check("add_regd",   out_regd,   32'h55);
    check("add_opAlu",  out_opAlu,  0);
    check("add_useImm", out_useImm, 0);
    check("add_wrReg",  out_wrReg,  1);
    check("add_rd",     out_rd,     3);
    check("add_pc",     out_pc,     32'h100);
    check("add_illegal", out_illegal, 0);
    step();
    check("add_drained", out_valid, 0);

    // MVHI
    send(32'h8B30_2222, 32'h104);
    in_valid = 1'b0;
    check("mvhi_isMvhi",  out_isMvhi,  1);
    check("mvhi_useZero", out_useZero, 1);
    check("mvhi_useImm",  out_useImm,  1);
    check("mvhi_immHi",   out_immHi,   16'h2222);
    check("mvhi_illegal", out_illegal, 0);
    check("mvhi_imm32",   out_imm32,   32'h0000_2222);

    // ADDI with negative immediate
    send(32'h8000_FFFE, 32'h108);
    in_valid = 1'b0;
    check("addi_imm32",   out_imm32,   32'hFFFF_FFFE);
    check("addi_useImm",  out_useImm,  1);
    check("addi_useZero", out_useZero, 0);
    check("addi_wrReg",   out_wrReg,   1);

    // BCOND GTZ
    send(32'h6F01_0004, 32'h10C);
    in_valid = 1'b0;
    check("br_opAlu",   out_opAlu,          4'b0001);
    check("br_opCond",  out_opCond,         4'b1111);
    check("br_useZero", out_useZero,        1);
    check("br_isBoC",   out_isBranchOrCond, 1);
    check("br_isBranch", out_isBranch,      1);
    check("br_wrReg",   out_wrReg,          0);
    check("br_useImm",  out_useImm,         0);
    check("br_imm32",   out_imm32,          32'h4);

    // Write-back bypass on rs1 only
    wb_en   = 1'b1;
    wb_idx  = 4'd1;
    wb_data = 32'd99;
    send(32'h0031_2000, 32'h110);
    in_valid = 1'b0;
    wb_en    = 1'b0;
    check("byp_reg1", out_reg1, 99);
    check("byp_reg2", out_reg2, 3);
    check("byp_regd", out_regd, 32'h55);

    // Legality
    send(32'h7031_2000, 32'h114);
    check("ill7_illegal", out_illegal, 1);
    check("ill7_wrReg",   out_wrReg,   0);
    check("ill7_isStore", out_isStore, 0);
    send(32'h9031_0010, 32'h118);
    check("lw_isLoad",  out_isLoad,  1);
    check("lw_wrReg",   out_wrReg,   1);
    check("lw_illegal", out_illegal, 0);
    send(32'h5131_0000, 32'h11C);
    check("sw_bad_illegal", out_illegal, 1);
    check("sw_bad_isStore", out_isStore, 0);
    send(32'h5031_0000, 32'h120);
    check("sw_isStore", out_isStore, 1);
    check("sw_useImm",  out_useImm,  1);
    check("sw_wrReg",   out_wrReg,   0);
    send(32'h0B31_2000, 32'h124);
    check("alur_b_illegal", out_illegal, 1);
    send(32'hB031_0000, 32'h128);
    check("jal_isJal", out_isJal, 1);
    check("jal_wrReg", out_wrReg, 1);
    send(32'h2C31_2000, 32'h12C);
    check("cmp_c_illegal", out_illegal, 1);
    in_valid = 1'b0;
    step();
    check("legal_drained", out_valid, 0);

    // Backpressure: A, B accepted, C held off, then ordered drain
    out_ready = 1'b0;
    send(32'h0031_2000, 32'hA0);
    check("bp_ready_a", in_ready, 1);
    send(32'h0031_2000, 32'hB0);
    check("bp_ready_b", in_ready, 0);
    check("bp_pc_a",    out_pc,   32'hA0);
    send(32'h0031_2000, 32'hC0);
    check("bp_stable_pc", out_pc,   32'hA0);
    check("bp_ready_c",   in_ready, 0);
    check("bp_valid",     out_valid, 1);
    out_ready = 1'b1;
    step();
    check("bp_pc_b",     out_pc,   32'hB0);
    check("bp_ready_re", in_ready, 1);
    step();
    check("bp_pc_c",    out_pc,    32'hC0);
    check("bp_valid_c", out_valid, 1);
    in_valid = 1'b0;
    step();
    check("bp_drained", out_valid, 0);

    // Flush with both entries full and in_valid asserted
    out_ready = 1'b0;
    send(32'h0031_2000, 32'hA0);
    send(32'h0031_2000, 32'hB0);
    flush = 1'b1;
    send(32'h0031_2000, 32'hD0);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_full_valid", out_valid, 0);
    check("fl_full_ready", in_ready,  1);
    step();
    check("fl_full_after", out_valid, 0);

    // Flush with only main full: the same-cycle accept is dropped
    send(32'h0031_2000, 32'hA0);
    flush = 1'b1;
    send(32'h0031_2000, 32'hE0);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_acc_valid", out_valid, 0);
    step();
    check("fl_acc_after", out_valid, 0);
    check("fl_acc_ready", in_ready,  1);

    // Asynchronous reset in the middle of backpressure
    send(32'h0031_2000, 32'hA0);
    send(32'h0031_2000, 32'hB0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready,  1);
    check("ar_pc",    out_pc,    0);
    check("ar_reg1",  out_reg1,  0);
    check("ar_wrReg", out_wrReg, 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    check("ar_after_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
